// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode constants and the CDB snoop helper for the integer
// reservation station.
package reservation_station_pkg;

   localparam int RS_SIZE = 16;
   localparam int RS_W    = 4;
   localparam int ROB_W   = 4;
   localparam int OP_W    = 6;
   localparam int DATA_W  = 32;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [DATA_W-1:0] NULL_DATA = '0;
   localparam logic [ROB_W-1:0]  NULL_TAG  = '0;
   localparam logic [OP_W-1:0]   NULL_OP   = '0;

   localparam logic [OP_W-1:0] OP_NOP = 6'd0;
   localparam logic [OP_W-1:0] OP_ADD = 6'd1;
   localparam logic [OP_W-1:0] OP_SUB = 6'd2;
   localparam logic [OP_W-1:0] OP_AND = 6'd3;
   localparam logic [OP_W-1:0] OP_OR  = 6'd4;
   localparam logic [OP_W-1:0] OP_XOR = 6'd5;
   localparam logic [OP_W-1:0] OP_SLL = 6'd6;
   localparam logic [OP_W-1:0] OP_SRL = 6'd7;
   localparam logic [OP_W-1:0] OP_SLT = 6'd8;

   // t=1 means v carries a pending ROB tag in its low ROB_W bits
   typedef struct packed {
      logic              t;
      logic [DATA_W-1:0] v;
   } operand_t;

   // Resolve a pending operand against both CDBs; the ALU bus wins a tie.
   function automatic operand_t snoop(
      input operand_t          opnd,
      input logic              a_s,
      input logic [ROB_W-1:0]  a_tag,
      input logic [DATA_W-1:0] a_val,
      input logic              l_s,
      input logic [ROB_W-1:0]  l_tag,
      input logic [DATA_W-1:0] l_val
   );
      operand_t res;
      res = opnd;
      if (opnd.t) begin
         if (a_s && (opnd.v[ROB_W-1:0] == a_tag)) begin
            res.t = DISABLE;
            res.v = a_val;
         end else if (l_s && (opnd.v[ROB_W-1:0] == l_tag)) begin
            res.t = DISABLE;
            res.v = l_val;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit encoder: idx is the lowest asserted request, found flags any.
module rs_priority_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan downward so the lowest set bit is the last one to assign.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Integer reservation station: holds dispatched ops, wakes operands from the
// ALU/LSB CDBs and issues the lowest-index ready entry to the ALU each cycle.
module reservation_station
   import reservation_station_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_in,

   input  logic              dsp_S,
   input  logic [OP_W-1:0]   dsp_Op,
   input  logic [DATA_W-1:0] dsp_A,
   input  logic [DATA_W-1:0] dsp_pc,
   input  logic [ROB_W-1:0]  dsp_Reorder,
   input  logic              dsp_Type_j,
   input  logic              dsp_Type_k,
   input  logic [DATA_W-1:0] dsp_Value_j,
   input  logic [DATA_W-1:0] dsp_Value_k,
   output logic [RS_W-1:0]   free_pos,
   output logic              full,

   input  logic              alu_cdb_S,
   input  logic [ROB_W-1:0]  alu_cdb_Reorder,
   input  logic [DATA_W-1:0] alu_cdb_value,
   input  logic              lsb_cdb_S,
   input  logic [ROB_W-1:0]  lsb_cdb_Reorder,
   input  logic [DATA_W-1:0] lsb_cdb_value,

   output logic              alu_S,
   output logic [OP_W-1:0]   alu_Op,
   output logic [DATA_W-1:0] alu_Vj,
   output logic [DATA_W-1:0] alu_Vk,
   output logic [DATA_W-1:0] alu_A,
   output logic [DATA_W-1:0] alu_pc,
   output logic [ROB_W-1:0]  alu_Reorder
);

   logic [RS_SIZE-1:0] busy_reg;
   logic [OP_W-1:0]    op_reg  [RS_SIZE];
   logic [DATA_W-1:0]  a_reg   [RS_SIZE];
   logic [DATA_W-1:0]  pc_reg  [RS_SIZE];
   logic [ROB_W-1:0]   rob_reg [RS_SIZE];
   operand_t           j_reg   [RS_SIZE];
   operand_t           k_reg   [RS_SIZE];

   operand_t           j_next  [RS_SIZE];
   operand_t           k_next  [RS_SIZE];
   logic [RS_SIZE-1:0] ready;

   operand_t           dsp_j;
   operand_t           dsp_k;
   logic               free_found;
   logic [RS_W-1:0]    issue_idx;
   logic               issue_found;
   logic               dsp_accept;

   // Readiness uses pre-edge state, so a wakeup this edge issues next cycle.
   generate
      for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
         assign j_next[gi] = snoop(j_reg[gi], alu_cdb_S, alu_cdb_Reorder, alu_cdb_value,
                                   lsb_cdb_S, lsb_cdb_Reorder, lsb_cdb_value);
         assign k_next[gi] = snoop(k_reg[gi], alu_cdb_S, alu_cdb_Reorder, alu_cdb_value,
                                   lsb_cdb_S, lsb_cdb_Reorder, lsb_cdb_value);
         assign ready[gi]  = busy_reg[gi] & ~j_reg[gi].t & ~k_reg[gi].t;
      end
   endgenerate

   assign dsp_j = snoop('{t: dsp_Type_j, v: dsp_Value_j}, alu_cdb_S, alu_cdb_Reorder,
                        alu_cdb_value, lsb_cdb_S, lsb_cdb_Reorder, lsb_cdb_value);
   assign dsp_k = snoop('{t: dsp_Type_k, v: dsp_Value_k}, alu_cdb_S, alu_cdb_Reorder,
                        alu_cdb_value, lsb_cdb_S, lsb_cdb_Reorder, lsb_cdb_value);

   rs_priority_enc #(.N(RS_SIZE), .W(RS_W)) u_free_enc (
      .req   (~busy_reg),
      .idx   (free_pos),
      .found (free_found)
   );

   rs_priority_enc #(.N(RS_SIZE), .W(RS_W)) u_issue_enc (
      .req   (ready),
      .idx   (issue_idx),
      .found (issue_found)
   );

   assign full       = ~free_found;
   assign dsp_accept = dsp_S & free_found;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_reg    <= '0;
         alu_S       <= DISABLE;
         alu_Op      <= NULL_OP;
         alu_Vj      <= NULL_DATA;
         alu_Vk      <= NULL_DATA;
         alu_A       <= NULL_DATA;
         alu_pc      <= NULL_DATA;
         alu_Reorder <= NULL_TAG;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_reg[i]  <= NULL_OP;
            a_reg[i]   <= NULL_DATA;
            pc_reg[i]  <= NULL_DATA;
            rob_reg[i] <= NULL_TAG;
            j_reg[i]   <= '0;
            k_reg[i]   <= '0;
         end
      end else if (rdy_in) begin
         if (clear_in) begin
            busy_reg <= '0;
            alu_S    <= DISABLE;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_reg[i]) begin
                  j_reg[i] <= j_next[i];
                  k_reg[i] <= k_next[i];
               end
            end

            if (issue_found) begin
               alu_S       <= ENABLE;
               alu_Op      <= op_reg[issue_idx];
               alu_Vj      <= j_reg[issue_idx].v;
               alu_Vk      <= k_reg[issue_idx].v;
               alu_A       <= a_reg[issue_idx];
               alu_pc      <= pc_reg[issue_idx];
               alu_Reorder <= rob_reg[issue_idx];
               busy_reg[issue_idx] <= DISABLE;
            end else begin
               alu_S <= DISABLE;
            end

            // free_pos is always an idle slot, so it never collides with issue.
            if (dsp_accept) begin
               busy_reg[free_pos] <= ENABLE;
               op_reg[free_pos]   <= dsp_Op;
               a_reg[free_pos]    <= dsp_A;
               pc_reg[free_pos]   <= dsp_pc;
               rob_reg[free_pos]  <= dsp_Reorder;
               j_reg[free_pos]    <= dsp_j;
               k_reg[free_pos]    <= dsp_k;
            end
         end
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues go into a scoreboard
// queue at dispatch time and are popped whenever alu_S fires.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b0;
   logic              rdy_in = 1'b1;
   logic              clear_in = 1'b0;
   logic              dsp_S = 1'b0;
   logic [OP_W-1:0]   dsp_Op = '0;
   logic [DATA_W-1:0] dsp_A = '0;
   logic [DATA_W-1:0] dsp_pc = '0;
   logic [ROB_W-1:0]  dsp_Reorder = '0;
   logic              dsp_Type_j = 1'b0;
   logic              dsp_Type_k = 1'b0;
   logic [DATA_W-1:0] dsp_Value_j = '0;
   logic [DATA_W-1:0] dsp_Value_k = '0;
   logic [RS_W-1:0]   free_pos;
   logic              full;
   logic              alu_cdb_S = 1'b0;
   logic [ROB_W-1:0]  alu_cdb_Reorder = '0;
   logic [DATA_W-1:0] alu_cdb_value = '0;
   logic              lsb_cdb_S = 1'b0;
   logic [ROB_W-1:0]  lsb_cdb_Reorder = '0;
   logic [DATA_W-1:0] lsb_cdb_value = '0;
   logic              alu_S;
   logic [OP_W-1:0]   alu_Op;
   logic [DATA_W-1:0] alu_Vj;
   logic [DATA_W-1:0] alu_Vk;
   logic [DATA_W-1:0] alu_A;
   logic [DATA_W-1:0] alu_pc;
   logic [ROB_W-1:0]  alu_Reorder;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] pc;
      logic [ROB_W-1:0]  rob;
   } exp_t;

   exp_t sb[$];
   int   cmp_cnt = 0;
   int   err_cnt = 0;

   reservation_station dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .clear_in        (clear_in),
      .dsp_S           (dsp_S),
      .dsp_Op          (dsp_Op),
      .dsp_A           (dsp_A),
      .dsp_pc          (dsp_pc),
      .dsp_Reorder     (dsp_Reorder),
      .dsp_Type_j      (dsp_Type_j),
      .dsp_Type_k      (dsp_Type_k),
      .dsp_Value_j     (dsp_Value_j),
      .dsp_Value_k     (dsp_Value_k),
      .free_pos        (free_pos),
      .full            (full),
      .alu_cdb_S       (alu_cdb_S),
      .alu_cdb_Reorder (alu_cdb_Reorder),
      .alu_cdb_value   (alu_cdb_value),
      .lsb_cdb_S       (lsb_cdb_S),
      .lsb_cdb_Reorder (lsb_cdb_Reorder),
      .lsb_cdb_value   (lsb_cdb_value),
      .alu_S           (alu_S),
      .alu_Op          (alu_Op),
      .alu_Vj          (alu_Vj),
      .alu_Vk          (alu_Vk),
      .alu_A           (alu_A),
      .alu_pc          (alu_pc),
      .alu_Reorder     (alu_Reorder)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] pc, input logic [ROB_W-1:0] rob);
      exp_t e;
      e = '{op: op, vj: vj, vk: vk, a: a, pc: pc, rob: rob};
      sb.push_back(e);
   endtask

   // One clock; any issue produced at this edge is checked against the scoreboard.
   task automatic tick();
      logic was_rdy;
      exp_t e;
      was_rdy = rdy_in;
      @(posedge clk_in);
      #1;
      if (was_rdy && alu_S === 1'b1) begin
         if (sb.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $error("FAIL unexpected_issue observed=alu_S=1 rob=%0d expected=no issue", alu_Reorder);
         end else begin
            e = sb.pop_front();
            $display("issue rob=%0d op=%0d vj=0x%0h vk=0x%0h a=0x%0h pc=0x%0h",
                     alu_Reorder, alu_Op, alu_Vj, alu_Vk, alu_A, alu_pc);
            chk("issue_rob", DATA_W'(alu_Reorder), DATA_W'(e.rob));
            chk("issue_op",  DATA_W'(alu_Op), DATA_W'(e.op));
            chk("issue_vj",  alu_Vj, e.vj);
            chk("issue_vk",  alu_Vk, e.vk);
            chk("issue_a",   alu_A, e.a);
            chk("issue_pc",  alu_pc, e.pc);
         end
      end
   endtask

   task automatic dispatch(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] pc,
                           input logic [ROB_W-1:0] rob, input logic tj, input logic [DATA_W-1:0] vj,
                           input logic tk, input logic [DATA_W-1:0] vk);
      dsp_S       = 1'b1;
      dsp_Op      = op;
      dsp_A       = a;
      dsp_pc      = pc;
      dsp_Reorder = rob;
      dsp_Type_j  = tj;
      dsp_Value_j = vj;
      dsp_Type_k  = tk;
      dsp_Value_k = vk;
      tick();
      dsp_S       = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_alu_S", DATA_W'(alu_S), 0);
      chk("rst_free_pos", DATA_W'(free_pos), 0);
      chk("rst_full", DATA_W'(full), 0);
      chk("rst_alu_Vj", alu_Vj, 0);
      chk("rst_alu_Reorder", DATA_W'(alu_Reorder), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      tick();

      // Ready dispatch issues one edge later
      push(OP_ADD, 5, 7, 32'h10, 32'h100, 3);
      dispatch(OP_ADD, 32'h10, 32'h100, 3, 1'b0, 5, 1'b0, 7);
      chk("ready_no_issue_yet", DATA_W'(alu_S), 0);
      chk("ready_free_pos", DATA_W'(free_pos), 1);
      tick();
      chk("ready_issue", DATA_W'(alu_S), 1);
      chk("ready_free_back", DATA_W'(free_pos), 0);

      // Wakeup from the ALU CDB
      push(OP_SUB, 32'h1234, 4, 0, 32'h104, 5);
      dispatch(OP_SUB, 0, 32'h104, 5, 1'b1, 9, 1'b0, 4);
      tick();
      chk("wake_withheld", DATA_W'(alu_S), 0);
      alu_cdb_S = 1'b1; alu_cdb_Reorder = 9; alu_cdb_value = 32'h1234;
      tick();
      alu_cdb_S = 1'b0;
      chk("wake_edge_no_issue", DATA_W'(alu_S), 0);
      tick();
      chk("wake_issue", DATA_W'(alu_S), 1);
      tick();
      chk("idle_alu_S", DATA_W'(alu_S), 0);
      chk("idle_hold_Vj", alu_Vj, 32'h1234);

      // Dispatch-cycle bypass from the LSB CDB
      lsb_cdb_S = 1'b1; lsb_cdb_Reorder = 2; lsb_cdb_value = 32'hAB;
      push(OP_AND, 1, 32'hAB, 0, 32'h108, 7);
      dispatch(OP_AND, 0, 32'h108, 7, 1'b0, 1, 1'b1, 2);
      lsb_cdb_S = 1'b0;
      tick();
      chk("bypass_issue", DATA_W'(alu_S), 1);

      // Both buses carry the same tag: ALU data wins
      push(OP_OR, 32'h111, 3, 0, 32'h10C, 8);
      dispatch(OP_OR, 0, 32'h10C, 8, 1'b1, 11, 1'b0, 3);
      alu_cdb_S = 1'b1; alu_cdb_Reorder = 11; alu_cdb_value = 32'h111;
      lsb_cdb_S = 1'b1; lsb_cdb_Reorder = 11; lsb_cdb_value = 32'h222;
      tick();
      alu_cdb_S = 1'b0; lsb_cdb_S = 1'b0;
      tick();
      chk("tie_issue", DATA_W'(alu_S), 1);

      // Fill all 16 slots with pending operands
      for (int i = 0; i < RS_SIZE; i++) begin
         dispatch(OP_XOR, DATA_W'(i), 32'h200 + DATA_W'(4 * i), ROB_W'(i), 1'b1, DATA_W'(i), 1'b0, 0);
         if (i < RS_SIZE - 1) chk("fill_free_pos", DATA_W'(free_pos), DATA_W'(i + 1));
      end
      chk("fill_full", DATA_W'(full), 1);
      chk("fill_free_pos_full", DATA_W'(free_pos), 0);
      dispatch(OP_ADD, 32'hDEAD, 32'hDEAD, 15, 1'b0, 1, 1'b0, 2);
      tick();
      chk("overflow_ignored", DATA_W'(alu_S), 0);
      chk("overflow_full", DATA_W'(full), 1);
      push(OP_XOR, 32'h4444, 0, 4, 32'h210, 4);
      alu_cdb_S = 1'b1; alu_cdb_Reorder = 4; alu_cdb_value = 32'h4444;
      tick();
      alu_cdb_S = 1'b0;
      tick();
      chk("slot4_issue", DATA_W'(alu_S), 1);
      chk("slot4_free_pos", DATA_W'(free_pos), 4);
      chk("slot4_not_full", DATA_W'(full), 0);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      chk("clear_after_fill", DATA_W'(free_pos), 0);

      // Ordering: slots 1 and 6 become ready on the same edge
      for (int s = 0; s < 7; s++) begin
         dispatch(OP_SUB, DATA_W'(s), 32'h300 + DATA_W'(s), ROB_W'(s), 1'b1,
                  (s == 1) ? 32'd1 : ((s == 6) ? 32'd6 : 32'd14), 1'b0, 0);
      end
      push(OP_SUB, 32'h1111, 0, 1, 32'h301, 1);
      push(OP_SUB, 32'h6666, 0, 6, 32'h306, 6);
      alu_cdb_S = 1'b1; alu_cdb_Reorder = 1; alu_cdb_value = 32'h1111;
      lsb_cdb_S = 1'b1; lsb_cdb_Reorder = 6; lsb_cdb_value = 32'h6666;
      tick();
      alu_cdb_S = 1'b0; lsb_cdb_S = 1'b0;
      tick();
      chk("order_first", DATA_W'(alu_Reorder), 1);
      tick();
      chk("order_second_S", DATA_W'(alu_S), 1);
      chk("order_second", DATA_W'(alu_Reorder), 6);

      // Flush with three busy entries and a concurrent dispatch
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      for (int s = 0; s < 3; s++) dispatch(OP_ADD, 0, 32'h380, ROB_W'(s), 1'b1, 14, 1'b0, 0);
      chk("pre_flush_free_pos", DATA_W'(free_pos), 3);
      clear_in = 1'b1;
      dispatch(OP_ADD, 0, 32'h390, 10, 1'b0, 1, 1'b0, 1);
      clear_in = 1'b0;
      chk("flush_alu_S", DATA_W'(alu_S), 0);
      chk("flush_free_pos", DATA_W'(free_pos), 0);
      chk("flush_full", DATA_W'(full), 0);
      tick();
      chk("flush_dropped", DATA_W'(alu_S), 0);

      // rdy_in low freezes dispatch and issue
      rdy_in = 1'b0;
      dispatch(OP_ADD, 0, 32'h3A0, 11, 1'b0, 1, 1'b0, 1);
      chk("frozen_dispatch", DATA_W'(free_pos), 0);
      rdy_in = 1'b1;
      push(6'd63, 32'h55, 32'h66, 32'h77, 32'h400, 12);
      dispatch(6'd63, 32'h77, 32'h400, 12, 1'b0, 32'h55, 1'b0, 32'h66);
      rdy_in = 1'b0;
      tick();
      chk("frozen_hold_S", DATA_W'(alu_S), 0);
      chk("frozen_busy", DATA_W'(free_pos), 1);
      rdy_in = 1'b1;
      tick();
      chk("unfrozen_issue", DATA_W'(alu_S), 1);

      // Asynchronous reset mid-cycle
      for (int s = 0; s < 3; s++) dispatch(OP_ADD, 0, 32'h480, ROB_W'(s), 1'b1, 14, 1'b0, 0);
      push(OP_ADD, 32'h99, 32'h98, 32'h97, 32'h500, 13);
      dispatch(OP_ADD, 32'h97, 32'h500, 13, 1'b0, 32'h99, 1'b0, 32'h98);
      tick();
      chk("pre_reset_issue", DATA_W'(alu_S), 1);
      #2;
      rst_in = 1'b0;
      #1;
      chk("async_rst_alu_S", DATA_W'(alu_S), 0);
      chk("async_rst_alu_Vj", alu_Vj, 0);
      chk("async_rst_alu_Reorder", DATA_W'(alu_Reorder), 0);
      chk("async_rst_free_pos", DATA_W'(free_pos), 0);
      chk("async_rst_full", DATA_W'(full), 0);
      #1;
      rst_in = 1'b1;
      tick();
      chk("post_reset_idle", DATA_W'(alu_S), 0);
      chk("scoreboard_empty", DATA_W'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
